// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHK,
    ST_APPEND,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  localparam logic [5:0]  HLT_OPCODE = 6'b111111;
  localparam logic [31:0] HLT_WORD   = {HLT_OPCODE, 26'd0};
  localparam int          HDR_BYTES  = 2;

endpackage

// File: rtl/byte_packer.sv
// Packs four stream bytes MSB-first into a 32-bit word; word_valid fires on the 4th byte.
module byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  assign word_valid = byte_valid && (cnt_q == 2'd3);
  assign word_data  = {shift_q, byte_data};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_data};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, big-endian words, XOR checksum; releases the core on a verified image.
// Optional HLT append after the image is enabled by defining LOADER_HLT_APPEND_EN.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for start
// ST_LEN_HI | accept high byte of word count N
// ST_LEN_LO | accept low byte of N, range-check it
// ST_DATA   | accept payload bytes, one memory write per 4 bytes
// ST_CHK    | accept checksum byte and compare with running XOR
// ST_APPEND | HLT word write at address N in flight
// ST_DONE   | image verified, core_run held high
// ST_ERROR  | bad length or checksum, load_error held high
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int LEN_W = 8 * HDR_BYTES;
  localparam int CNT_W = ADDR_W + 1;

`ifdef LOADER_HLT_APPEND_EN
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH - 1);
`else
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);
`endif

  loader_state_e    state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_next;
  logic [7:0]       chk_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic             xfer;
  logic             start_ok;
  logic             last_word;
  logic             chk_match;
  logic             pk_word_valid;
  logic [31:0]      pk_word;

  assign in_ready   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHK);
  assign core_run   = (state_q == ST_DONE);
  assign load_error = (state_q == ST_ERROR);
  assign xfer       = in_valid && in_ready;
  assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_ERROR));
  assign len_next   = {len_q[LEN_W-1:8], in_data};
  assign last_word  = ({{(LEN_W-CNT_W){1'b0}}, word_cnt_q} == (len_q - LEN_W'(1)));
  assign chk_match  = (in_data == chk_q);

  byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (xfer && (state_q == ST_DATA)),
    .byte_data  (in_data),
    .word_valid (pk_word_valid),
    .word_data  (pk_word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LEN_HI;
      ST_LEN_HI: if (in_valid) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (in_valid) begin
          if (len_next > LEN_MAX)     state_d = ST_ERROR;
          else if (len_next == '0)    state_d = ST_CHK;
          else                        state_d = ST_DATA;
        end
      end
      ST_DATA:   if (pk_word_valid && last_word) state_d = ST_CHK;
      ST_CHK: begin
        if (in_valid) begin
`ifdef LOADER_HLT_APPEND_EN
          state_d = chk_match ? ST_APPEND : ST_ERROR;
`else
          state_d = chk_match ? ST_DONE : ST_ERROR;
`endif
        end
      end
`ifdef LOADER_HLT_APPEND_EN
      ST_APPEND: state_d = ST_DONE;
`endif
      ST_DONE:   if (start) state_d = ST_LEN_HI;
      ST_ERROR:  if (start) state_d = ST_LEN_HI;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      chk_q        <= '0;
      word_cnt_q   <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      state_q <= state_d;
      mem_we  <= 1'b0;
      if (start_ok) begin
        len_q        <= '0;
        chk_q        <= '0;
        word_cnt_q   <= '0;
        words_loaded <= '0;
      end
      // The checksum byte itself is not folded into the running XOR.
      if (xfer && (state_q != ST_CHK)) chk_q <= chk_q ^ in_data;
      if (xfer && (state_q == ST_LEN_HI)) len_q[LEN_W-1:8] <= in_data;
      if (xfer && (state_q == ST_LEN_LO)) len_q[7:0] <= in_data;
      if (pk_word_valid) begin
        mem_we       <= 1'b1;
        mem_addr     <= word_cnt_q[ADDR_W-1:0];
        mem_wdata    <= pk_word;
        word_cnt_q   <= word_cnt_q + CNT_W'(1);
        words_loaded <= words_loaded + CNT_W'(1);
      end
`ifdef LOADER_HLT_APPEND_EN
      if (xfer && (state_q == ST_CHK) && chk_match) begin
        mem_we       <= 1'b1;
        mem_addr     <= len_q[ADDR_W-1:0];
        mem_wdata    <= HLT_WORD;
        words_loaded <= words_loaded + CNT_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a monitor pops them on mem_we.
module tb_imem_loader;
  import loader_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int WL_W   = ADDR_W + 1;
`ifdef LOADER_HLT_APPEND_EN
  localparam int APP = 1;
`else
  localparam int APP = 0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_run;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_run     (core_run),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    logic [WL_W-1:0]   wl;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  byte_q[$];
  logic [31:0] img [0:3];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && mem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h want no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("mem_addr", 32'(mem_addr), 32'(mon_e.a));
        check("mem_wdata", mem_wdata, mon_e.d);
        check("words_loaded_at_we", 32'(words_loaded), 32'(mon_e.wl));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit start_in_gap);
    int n;
    bit ok;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      if (start_in_gap && g == 0) start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    in_data  = b;
    in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_timeout: got in_ready 0 want 1 for byte %h", b);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_all(input int max_gap, input int start_at);
    int gap;
    for (int i = 0; i < byte_q.size(); i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (i == start_at && gap == 0) gap = 1;
      send_byte(byte_q[i], gap, i == start_at);
    end
  endtask

  task automatic build(input logic [15:0] hdr, input int nw, input bit bad);
    logic [7:0] c;
    byte_q.delete();
    byte_q.push_back(hdr[15:8]);
    byte_q.push_back(hdr[7:0]);
    for (int i = 0; i < nw; i++) begin
      for (int k = 3; k >= 0; k--) byte_q.push_back(img[i][8*k +: 8]);
      exp_q.push_back({ADDR_W'(i), img[i], WL_W'(i + 1)});
    end
    c = 8'h00;
    foreach (byte_q[j]) c = c ^ byte_q[j];
    byte_q.push_back(bad ? ~c : c);
    if (APP == 1 && !bad) exp_q.push_back({ADDR_W'(nw), HLT_WORD, WL_W'(nw + 1)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic status(input string tag, input bit run, input bit err, input int wl);
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_core_run"}, 32'(core_run), 32'(run));
    check({tag, "_load_error"}, 32'(load_error), 32'(err));
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'(wl));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_core_run", 32'(core_run), 32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // normal two-word load
    img[0] = 32'h20010005;
    img[1] = 32'hFC000000;
    build(16'd2, 2, 1'b0);
    pulse_start();
    send_all(0, -1);
    status("normal", 1'b1, 1'b0, 2 + APP);

    // bad checksum; restart from DONE must drop core_run
    pulse_start();
    check("restart_core_run", 32'(core_run), 32'd0);
    build(16'd2, 2, 1'b1);
    send_all(0, -1);
    status("badchk", 1'b0, 1'b1, 2);

    // zero-length image
    pulse_start();
    check("restart_load_error", 32'(load_error), 32'd0);
    build(16'd0, 0, 1'b0);
    send_all(0, -1);
    status("zero", 1'b1, 1'b0, APP);

    // oversize header 1025
    byte_q.delete();
    byte_q.push_back(8'h04);
    byte_q.push_back(8'h01);
    pulse_start();
    send_all(0, -1);
    @(negedge clock);
    check("over_load_error", 32'(load_error), 32'd1);
    check("over_in_ready", 32'(in_ready), 32'd0);
    check("over_words_loaded", 32'(words_loaded), 32'd0);

    // header exactly DEPTH: accepted unless a HLT slot must be reserved
    byte_q.delete();
    byte_q.push_back(8'h04);
    byte_q.push_back(8'h00);
    @(posedge clock);
    #1;
    pulse_start();
    send_all(0, -1);
    @(negedge clock);
    check("depth_load_error", 32'(load_error), 32'(APP));
    check("depth_in_ready", 32'(in_ready), 32'(1 - APP));
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;

    // gaps on in_valid and a start pulse mid-DATA
    img[0] = 32'h11223344;
    img[1] = 32'hA5A50F0F;
    img[2] = 32'hFC000000;
    build(16'd3, 3, 1'b0);
    pulse_start();
    send_all(3, 7);
    status("gaps", 1'b1, 1'b0, 3 + APP);

    // reset after 6 payload bytes, then a clean reload
    img[0] = 32'h20010005;
    img[1] = 32'hFC000000;
    build(16'd2, 2, 1'b0);
    exp_q.delete();
    exp_q.push_back({ADDR_W'(0), 32'h20010005, WL_W'(1)});
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(byte_q[i], 0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_words_loaded", 32'(words_loaded), 32'd0);
    check("mid_rst_mem_wdata", mem_wdata, 32'd0);
    check("mid_rst_pending_writes", 32'(exp_q.size()), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    build(16'd2, 2, 1'b0);
    pulse_start();
    send_all(0, -1);
    status("reload", 1'b1, 1'b0, 2 + APP);

    if (APP == 1) begin
      img[0] = 32'h28010007;
      build(16'd1, 1, 1'b0);
      pulse_start();
      send_all(0, -1);
      status("append", 1'b1, 1'b0, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
